// File: rtl/ahb_slave_mux_n_pkg.sv
// Shared constants and types for the AHB-Lite slave-to-master response mux.
package ahb_mux_pkg;

    localparam int unsigned HRESP_W  = 2;
    localparam int unsigned HTRANS_W = 2;

    localparam logic [HRESP_W-1:0] HRESP_OKAY  = 2'b00;
    localparam logic [HRESP_W-1:0] HRESP_ERROR = 2'b01;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } d_state_e;

    // Response produced by the built-in default slave.
    typedef struct packed {
        logic               hready;
        logic [HRESP_W-1:0] hresp;
    } def_resp_t;

endpackage

// File: rtl/ahb_slave_mux_n_if.sv
// Bus bundle between decoder/slaves/master and the response mux.
interface ahb_slave_mux_n_if
    import ahb_mux_pkg::*;
#(
    parameter int unsigned NO_OF_SLAVES = 4,
    parameter int unsigned DATA_WIDTH   = 32
);
    logic [NO_OF_SLAVES-1:0]            HSEL;
    logic [HTRANS_W-1:0]                HTRANS;
    logic [NO_OF_SLAVES-1:0]            HREADYOUT_BUS;
    logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_BUS;
    logic [HRESP_W*NO_OF_SLAVES-1:0]    HRESP_BUS;
    logic [DATA_WIDTH-1:0]              HRDATA;
    logic [HRESP_W-1:0]                 HRESP;
    logic                               HREADY;
    logic                               MULTI_SEL_ERR;
    logic                               TIMEOUT_ERR;

    modport master (
        output HSEL, HTRANS, HREADYOUT_BUS, HRDATA_BUS, HRESP_BUS,
        input  HRDATA, HRESP, HREADY, MULTI_SEL_ERR, TIMEOUT_ERR
    );

    modport slave (
        input  HSEL, HTRANS, HREADYOUT_BUS, HRDATA_BUS, HRESP_BUS,
        output HRDATA, HRESP, HREADY, MULTI_SEL_ERR, TIMEOUT_ERR
    );
endinterface

// File: rtl/ahb_slave_mux_n_default_resp.sv
// Default-slave FSM (two-cycle ERROR) plus the stall watchdog that forces ERROR on hung slaves.
module ahb_mux_default_resp
    import ahb_mux_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic      HCLK,
    input  logic      HRESET,
    input  logic      accept,
    input  logic      unmapped_active,
    input  logic      sel_active,
    input  logic      sel_ready,
    output def_resp_t def_resp_c,
    output logic      timeout_fire_c,
    output logic      TIMEOUT_ERR
);

    d_state_e state_q;
    d_state_e state_d;

    // State register and timeout pulse.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= D_IDLE;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state_q     <= state_d;
            TIMEOUT_ERR <= timeout_fire_c;
        end
    end

    // Next state: ERR1 always advances; acceptance and watchdog override.
    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE:  state_d = D_IDLE;
            D_ERR1:  state_d = D_ERR2;
            D_ERR2:  state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
        if (timeout_fire_c) begin
            state_d = D_ERR1;
        end else if (accept) begin
            state_d = unmapped_active ? D_ERR1 : D_IDLE;
        end
    end

    // Output decode kept apart from next-state so HREADY never depends on accept.
    always_comb begin
        def_resp_c.hready = 1'b1;
        def_resp_c.hresp  = HRESP_OKAY;
        case (state_q)
            D_ERR1: begin
                def_resp_c.hready = 1'b0;
                def_resp_c.hresp  = HRESP_ERROR;
            end
            D_ERR2: def_resp_c.hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    if (TIMEOUT > 0) begin : g_wdog
        localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

        logic [CNT_W-1:0] cnt_q;
        logic             stalled;

        assign stalled = sel_active && !sel_ready;
        // The compare counts the current wait cycle, so the master sees exactly TIMEOUT waits.
        assign timeout_fire_c = stalled && (cnt_q == CNT_W'(TIMEOUT - 1));

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                cnt_q <= '0;
            end else if (accept || timeout_fire_c || !stalled) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end else begin : g_no_wdog
        assign timeout_fire_c = 1'b0;
    end

endmodule

// File: rtl/ahb_slave_mux_n.sv
// AHB-Lite response mux for N slaves: data-phase select, output mux, multi-hot detect.
module ahb_slave_mux_n
    import ahb_mux_pkg::*;
#(
    parameter int unsigned NO_OF_SLAVES = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_slave_mux_n_if.slave   bus
);

    localparam int unsigned NS = NO_OF_SLAVES;
    localparam int unsigned DW = DATA_WIDTH;

    logic [NS-1:0]      data_sel;
    logic               multi_sel_err_q;
    logic               accept;
    logic               trans_active;
    logic               sel_multi;
    logic               sel_onehot;
    logic               unmapped_active;
    logic               sel_active;
    logic               sel_ready;
    logic [DW-1:0]      sel_rdata;
    logic [HRESP_W-1:0] sel_resp;
    def_resp_t          def_resp_c;
    logic               timeout_fire_c;
    logic               timeout_err;

    assign accept       = bus.HREADY;
    assign trans_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

    if (NS == 1) begin : g_single
        assign sel_multi = 1'b0;
    end else begin : g_multi
        // Clearing the lowest set bit leaves something only when more than one bit is set.
        assign sel_multi = |(bus.HSEL & (bus.HSEL - NS'(1)));
    end

    assign sel_onehot      = (|bus.HSEL) && !sel_multi;
    assign unmapped_active = !sel_onehot && trans_active;
    assign sel_active      = |data_sel;

    // Data-phase select and sticky multi-select flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_sel        <= '0;
            multi_sel_err_q <= 1'b0;
        end else begin
            if (timeout_fire_c) begin
                data_sel <= '0;
            end else if (accept) begin
                data_sel <= sel_onehot ? bus.HSEL : '0;
            end
            if (accept && sel_multi) begin
                multi_sel_err_q <= 1'b1;
            end
        end
    end

    // AND-OR mux over the one-hot data-phase select.
    always_comb begin
        sel_rdata = '0;
        sel_resp  = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            if (data_sel[i]) begin
                sel_rdata = sel_rdata | bus.HRDATA_BUS[i*DW +: DW];
                sel_resp  = sel_resp  | bus.HRESP_BUS[i*HRESP_W +: HRESP_W];
                sel_ready = sel_ready | bus.HREADYOUT_BUS[i];
            end
        end
    end

    ahb_mux_default_resp #(
        .TIMEOUT (TIMEOUT)
    ) u_default_resp (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .accept          (accept),
        .unmapped_active (unmapped_active),
        .sel_active      (sel_active),
        .sel_ready       (sel_ready),
        .def_resp_c      (def_resp_c),
        .timeout_fire_c  (timeout_fire_c),
        .TIMEOUT_ERR     (timeout_err)
    );

    assign bus.HRDATA        = sel_rdata;
    assign bus.HRESP         = sel_active ? sel_resp  : def_resp_c.hresp;
    assign bus.HREADY        = sel_active ? sel_ready : def_resp_c.hready;
    assign bus.MULTI_SEL_ERR = multi_sel_err_q;
    assign bus.TIMEOUT_ERR   = timeout_err;

endmodule

// File: tb/tb_ahb_slave_mux_n.sv
// Directed bench for ahb_slave_mux_n: per-cycle vector table plus hand-written watchdog/reset sequences.
module tb_ahb_slave_mux_n;
    import ahb_mux_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
    localparam int          NV = 20;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    always #5 HCLK = ~HCLK;

    ahb_slave_mux_n_if #(.NO_OF_SLAVES(NS), .DATA_WIDTH(DW)) bus ();

    ahb_slave_mux_n #(
        .NO_OF_SLAVES (NS),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (TO)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  hsel;
        logic [1:0]  htrans;
        logic [3:0]  rdy;
        logic [7:0]  resp_bus;
        logic        exp_hready;
        logic [1:0]  exp_hresp;
        logic [31:0] exp_hrdata;
        logic        exp_mse;
        logic        exp_terr;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [1:0] OK = HRESP_OKAY;
    localparam logic [1:0] ER = HRESP_ERROR;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] hsel, input logic [1:0] htrans,
                         input logic [3:0] rdy, input logic [7:0] resp_bus);
        bus.HSEL          = hsel;
        bus.HTRANS        = htrans;
        bus.HREADYOUT_BUS = rdy;
        bus.HRESP_BUS     = resp_bus;
    endtask

    task automatic check_out(input string tag, input logic hr, input logic [1:0] rs,
                             input logic [31:0] rd, input logic mse, input logic te);
        check({tag, ".HREADY"},        32'(bus.HREADY),        32'(hr));
        check({tag, ".HRESP"},         32'(bus.HRESP),         32'(rs));
        check({tag, ".HRDATA"},        bus.HRDATA,             rd);
        check({tag, ".MULTI_SEL_ERR"}, 32'(bus.MULTI_SEL_ERR), 32'(mse));
        check({tag, ".TIMEOUT_ERR"},   32'(bus.TIMEOUT_ERR),   32'(te));
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Each row is one bus cycle: inputs driven that cycle and the outputs expected in it.
        vecs[0]  = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[1]  = '{4'b0100, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[2]  = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, OK, 32'hCAFE_0002, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[4]  = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b0, ER, 32'h0,         1'b0, 1'b0};
        vecs[5]  = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, ER, 32'h0,         1'b0, 1'b0};
        vecs[6]  = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[7]  = '{4'b0010, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[8]  = '{4'b0000, HTRANS_SEQ,    4'hF, 8'h00, 1'b1, OK, 32'hCAFE_0001, 1'b0, 1'b0};
        vecs[9]  = '{4'b1000, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b0, ER, 32'h0,         1'b0, 1'b0};
        vecs[10] = '{4'b1000, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b1, ER, 32'h0,         1'b0, 1'b0};
        vecs[11] = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, OK, 32'hCAFE_0003, 1'b0, 1'b0};
        vecs[12] = '{4'b0010, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[13] = '{4'b0000, HTRANS_IDLE,   4'hD, 8'h00, 1'b0, OK, 32'hCAFE_0001, 1'b0, 1'b0};
        vecs[14] = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h04, 1'b1, ER, 32'hCAFE_0001, 1'b0, 1'b0};
        vecs[15] = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h04, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[16] = '{4'b0011, HTRANS_NONSEQ, 4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b0, 1'b0};
        vecs[17] = '{4'b0000, HTRANS_BUSY,   4'hF, 8'h00, 1'b0, ER, 32'h0,         1'b1, 1'b0};
        vecs[18] = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, ER, 32'h0,         1'b1, 1'b0};
        vecs[19] = '{4'b0000, HTRANS_IDLE,   4'hF, 8'h00, 1'b1, OK, 32'h0,         1'b1, 1'b0};

        bus.HRDATA_BUS = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        drive(4'b0000, HTRANS_IDLE, 4'hF, 8'h00);

        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check_out("reset", 1'b1, OK, 32'h0, 1'b0, 1'b0);
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].hsel, vecs[i].htrans, vecs[i].rdy, vecs[i].resp_bus);
            @(negedge HCLK);
            check_out($sformatf("vec%0d", i), vecs[i].exp_hready, vecs[i].exp_hresp,
                      vecs[i].exp_hrdata, vecs[i].exp_mse, vecs[i].exp_terr);
            step();
        end

        // Watchdog: slave0 hangs, four waits pass through, then ERR1 with pulse, then ERR2.
        drive(4'b0001, HTRANS_NONSEQ, 4'hF, 8'h00);
        @(negedge HCLK);
        check_out("wd_addr", 1'b1, OK, 32'h0, 1'b1, 1'b0);
        step();
        for (int w = 1; w <= 4; w++) begin
            drive(4'b0000, HTRANS_IDLE, 4'hE, 8'h00);
            @(negedge HCLK);
            check_out($sformatf("wd_wait%0d", w), 1'b0, OK, 32'hCAFE_0000, 1'b1, 1'b0);
            step();
        end
        @(negedge HCLK);
        check_out("wd_err1", 1'b0, ER, 32'h0, 1'b1, 1'b1);
        step();
        @(negedge HCLK);
        check_out("wd_err2", 1'b1, ER, 32'h0, 1'b1, 1'b0);
        step();
        drive(4'b0000, HTRANS_IDLE, 4'hF, 8'h00);
        @(negedge HCLK);
        check_out("wd_idle", 1'b1, OK, 32'h0, 1'b1, 1'b0);
        step();

        // Slave becomes ready on the 4th data-phase cycle: completes OKAY, no timeout.
        drive(4'b0001, HTRANS_NONSEQ, 4'hF, 8'h00);
        @(negedge HCLK);
        check_out("wr_addr", 1'b1, OK, 32'h0, 1'b1, 1'b0);
        step();
        for (int w = 1; w <= 3; w++) begin
            drive(4'b0000, HTRANS_IDLE, 4'hE, 8'h00);
            @(negedge HCLK);
            check_out($sformatf("wr_wait%0d", w), 1'b0, OK, 32'hCAFE_0000, 1'b1, 1'b0);
            step();
        end
        drive(4'b0000, HTRANS_IDLE, 4'hF, 8'h00);
        @(negedge HCLK);
        check_out("wr_done", 1'b1, OK, 32'hCAFE_0000, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            check_out($sformatf("wr_after%0d", k), 1'b1, OK, 32'h0, 1'b1, 1'b0);
            step();
        end

        // One-cycle reset in the middle of a stall releases HREADY and clears the sticky flag.
        drive(4'b0100, HTRANS_NONSEQ, 4'hF, 8'h00);
        @(negedge HCLK);
        check_out("rs_addr", 1'b1, OK, 32'h0, 1'b1, 1'b0);
        step();
        drive(4'b0000, HTRANS_IDLE, 4'hB, 8'h00);
        @(negedge HCLK);
        check_out("rs_stall", 1'b0, OK, 32'hCAFE_0002, 1'b1, 1'b0);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        @(negedge HCLK);
        check_out("rs_after", 1'b1, OK, 32'h0, 1'b0, 1'b0);
        step();

        // Multi-hot HSEL with IDLE: flag still sets, zero-wait OKAY.
        drive(4'b0110, HTRANS_IDLE, 4'hF, 8'h00);
        @(negedge HCLK);
        check_out("mi_addr", 1'b1, OK, 32'h0, 1'b0, 1'b0);
        step();
        drive(4'b0000, HTRANS_IDLE, 4'hF, 8'h00);
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            check_out($sformatf("mi_data%0d", k), 1'b1, OK, 32'h0, 1'b1, 1'b0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mux_n.md
Name: ahb_slave_mux_n

Overview:
- Parametrised AHB-Lite slave-to-master response multiplexer for N slaves.
- Sits between the decoder/slaves and the single master.
- Registers the address-phase select into a data-phase select, muxes HRDATA/HRESP/HREADY from the selected slave, and generates HREADY for all slaves.
- Adds behaviour the fixed 4-slave mux lacks:
  - built-in default slave with the two-cycle ERROR response;
  - detection of a multi-hot HSEL;
  - a stall watchdog that terminates hung transfers.

Parameters:
NO_OF_SLAVES, 4, number of slave ports (>=1)
DATA_WIDTH, 32, read-data width
TIMEOUT, 16, max consecutive slave wait cycles before forced ERROR; 0 disables watchdog

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  NO_OF_SLAVES  address-phase slave selects from decoder, bit i = slave i
HTRANS  in  2  address-phase transfer type from master
HREADYOUT_BUS  in  NO_OF_SLAVES  per-slave HREADYOUT, bit i = slave i
HRDATA_BUS  in  NO_OF_SLAVES*DATA_WIDTH  slave i at [i*DATA_WIDTH +: DATA_WIDTH]
HRESP_BUS  in  2*NO_OF_SLAVES  slave i at [2*i +: 2]
HRDATA  out  DATA_WIDTH  muxed read data to master
HRESP  out  2  muxed response (00 OKAY, 01 ERROR)
HREADY  out  1  muxed ready to master and all slaves
MULTI_SEL_ERR  out  1  sticky flag, set on accepted multi-hot HSEL
TIMEOUT_ERR  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (HRESET=1 at HCLK edge):
  - data_sel=0, FSM=D_IDLE, wait counter=0;
  - outputs HREADY=1, HRESP=00, HRDATA=0, MULTI_SEL_ERR=0, TIMEOUT_ERR=0.
  - Asserting reset mid-transfer abandons it; outputs are idle on the cycle after the edge.
- Address phase is accepted on a rising edge with HREADY=1. On acceptance:
  - HSEL one-hot: data_sel<=HSEL, FSM stays D_IDLE.
  - HSEL zero or multi-hot with HTRANS[1]=1 (NONSEQ/SEQ): data_sel<=0, FSM<=D_ERR1.
  - HSEL zero or multi-hot with HTRANS[1]=0 (IDLE/BUSY): data_sel<=0, FSM<=D_IDLE (zero-wait OKAY).
  - Multi-hot HSEL sets MULTI_SEL_ERR regardless of HTRANS; it clears only on reset.
- No state update when HREADY=0, except the FSM advance and watchdog below.
- Output mux (combinational from registered state):
  - data_sel bit i set: HRDATA/HRESP/HREADY = slave i fields.
  - data_sel=0: HRDATA=0. Default FSM drives the rest:
    - D_IDLE: HREADY=1, HRESP=00.
    - D_ERR1: HREADY=0, HRESP=01; unconditionally next state D_ERR2.
    - D_ERR2: HREADY=1, HRESP=01. Acceptance rules apply this cycle, so back-to-back unmapped transfers go ERR2->ERR1.
- Latency:
  - Mapped slaves add zero wait states; the data phase follows the address phase directly.
  - Unmapped active transfers take exactly 2 data-phase cycles.
- Watchdog (TIMEOUT>0):
  - Counter width $clog2(TIMEOUT+1), saturating.
  - Increments each cycle with data_sel!=0 and the selected HREADYOUT=0; clears when it is 1 or on any acceptance.
  - When the counter equals TIMEOUT and the selected HREADYOUT is still 0 at the edge: data_sel<=0, FSM<=D_ERR1, TIMEOUT_ERR=1 for that ERR1 cycle, counter<=0.
  - The master therefore sees TIMEOUT slave wait cycles, then ERR1, then ERR2.
  - If the slave raises HREADYOUT in the same cycle the counter reaches TIMEOUT, the slave response wins and no timeout occurs.
- TIMEOUT=0: counter absent, no forced termination.
- NO_OF_SLAVES=1: HSEL is 1 bit; the multi-hot check is constant 0.

Decomposition:
- Package ahb_mux_pkg holds:
  - HRESP_OKAY=2'b00, HRESP_ERROR=2'b01;
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - default-FSM state encoding D_IDLE/D_ERR1/D_ERR2.
- One sub-module, ahb_mux_default_resp, contains the FSM plus watchdog counter and outputs default HREADY/HRESP, timeout_fire and TIMEOUT_ERR.
- The top module holds data_sel, the one-hot/multi-hot check and the output mux.

Test Plan:
- Reset, then idle: HREADY=1, HRESP=00, HRDATA=0; HRESET high for 1 cycle mid-stall returns HREADY=1 on the next cycle.
- Mapped read:
  - stimulus: HSEL=4'b0100, HTRANS=NONSEQ, then slave2 HRDATA=32'hCAFE_0002, HREADYOUT=1;
  - response: next cycle HRDATA=32'hCAFE_0002, HRESP=00, HREADY=1, no wait state.
- Unmapped:
  - stimulus: HSEL=0, HTRANS=NONSEQ;
  - response: data phase {HREADY,HRESP}=(0,01) then (1,01); the same with HTRANS=IDLE gives (1,00) in one cycle.
- Back-to-back: slave1 transfer, unmapped NONSEQ, slave3 transfer -> OKAY, ERR1, ERR2, OKAY with correct HRDATA source each phase.
- Multi-hot:
  - stimulus: HSEL=4'b0011 with NONSEQ;
  - response: MULTI_SEL_ERR rises and stays 1, two-cycle ERROR, HRDATA=0.
- Watchdog with TIMEOUT=4:
  - stimulus: slave0 holds HREADYOUT=0;
  - response: 4 wait cycles passed through, then ERR1 with TIMEOUT_ERR=1, then ERR2;
  - with HREADYOUT=1 on the 4th cycle, a normal OKAY completes and TIMEOUT_ERR stays 0.
